// File: rtl/key_pkg.sv
// Shared types for the key press sequencer: key code, 6x7 press matrix,
// sequencer states and the code-to-matrix decoder.
package key_pkg;
  localparam int KEY_COLS = 6;
  localparam int KEY_ROWS = 7;
  localparam int NUM_KEYS = 42;

  typedef logic [5:0] key_code_t;
  typedef logic [KEY_COLS-1:0][KEY_ROWS-1:0] key_matrix_t;
  typedef enum logic [1:0] {IDLE, PRESS, GAP} seq_state_e;

  // Bit index col*7+row equals the code itself because rows are the inner
  // dimension; codes >= 42 shift out and decode to an all-zero matrix.
  function automatic key_matrix_t code_to_matrix(input key_code_t code);
    logic [NUM_KEYS-1:0] w_flat;
    w_flat = NUM_KEYS'(1) << code;
    return key_matrix_t'(w_flat);
  endfunction
endpackage

// File: rtl/key_cmd_fifo.sv
// Small synchronous FIFO for queued key codes, with a flush for abort.
module key_cmd_fifo
  import key_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  key_code_t              wdata,
  output key_code_t              rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  key_code_t       r_mem [DEPTH];
  logic [AW-1:0]   r_wptr, r_rptr;
  logic [AW:0]     r_count;
  logic            w_push, w_pop;

  assign full   = (r_count == (AW+1)'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign rdata  = r_mem[r_rptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/key_press_sequencer.sv
// Turns queued key codes into timed press/gap events on the 6x7 key matrix
// driving the payphone keyboard emulator.
module key_press_sequencer
  import key_pkg::*;
#(
  parameter int PRESS_CYCLES = 2_000_000,
  parameter int GAP_CYCLES   = 1_500_000,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [5:0]                  cmd_key,
  input  logic                        abort,
  output logic [5:0][6:0]             state,
  output logic                        busy,
  output logic                        err_pulse,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int MAX_CYC = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
  localparam int TW      = $clog2(MAX_CYC + 1);
  localparam logic [TW-1:0] PRESS_LOAD = TW'(PRESS_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD   = TW'(GAP_CYCLES - 1);

  seq_state_e  r_fsm;
  key_matrix_t r_state;
  logic [TW-1:0] r_timer;
  logic        r_err;
  logic        w_full, w_empty, w_legal, w_xfer, w_push, w_pop;
  key_code_t   w_head;

  assign w_legal = (cmd_key < 6'(NUM_KEYS));
  assign w_xfer  = cmd_valid && !w_full && !abort;
  assign w_push  = w_xfer && w_legal;
  // A pop only happens where a new press can start: from IDLE or at gap end.
  assign w_pop   = !abort && !w_empty &&
                   ((r_fsm == IDLE) || ((r_fsm == GAP) && (r_timer == '0)));

  key_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .flush (abort),
    .wdata (cmd_key),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm   <= IDLE;
      r_state <= '0;
      r_timer <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_xfer && !w_legal;
      if (abort) begin
        r_fsm   <= GAP;
        r_timer <= GAP_LOAD;
        r_state <= '0;
      end else begin
        case (r_fsm)
          IDLE: if (w_pop) begin
            r_state <= code_to_matrix(w_head);
            r_timer <= PRESS_LOAD;
            r_fsm   <= PRESS;
          end
          PRESS: if (r_timer == '0) begin
            r_state <= '0;
            r_timer <= GAP_LOAD;
            r_fsm   <= GAP;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
          GAP: if (r_timer != '0) begin
            r_timer <= r_timer - 1'b1;
          end else if (w_pop) begin
            r_state <= code_to_matrix(w_head);
            r_timer <= PRESS_LOAD;
            r_fsm   <= PRESS;
          end else begin
            r_fsm <= IDLE;
          end
          default: r_fsm <= IDLE;
        endcase
      end
    end
  end

  assign state     = r_state;
  assign err_pulse = r_err;
  assign cmd_ready = !w_full;
  assign busy      = (r_fsm != IDLE) || !w_empty;
endmodule

// File: tb/tb_key_press_sequencer.sv
// Randomized + directed bench for key_press_sequencer against a queue/countdown model.
module tb_key_press_sequencer;
  localparam int PRESS = 4;
  localparam int GAP   = 3;
  localparam int DEPTH = 4;

  logic            clk = 0;
  logic            rst_n = 0;
  logic            cmd_valid = 0;
  logic            cmd_ready;
  logic [5:0]      cmd_key = '0;
  logic            abort = 0;
  logic [5:0][6:0] state;
  logic            busy;
  logic            err_pulse;
  logic [2:0]      fifo_count;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 0;

  key_press_sequencer #(
    .PRESS_CYCLES(PRESS), .GAP_CYCLES(GAP), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_key(cmd_key), .abort(abort), .state(state), .busy(busy),
    .err_pulse(err_pulse), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: the queue of legal keys, the key currently held, and how many
  // cycles of press / release remain.
  int m_q[$];
  int m_key = -1;
  int m_press = 0;
  int m_gap = 0;
  bit m_err = 0;
  bit m_rdy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete(); m_key = -1; m_press = 0; m_gap = 0; m_err = 0;
    end else begin
      m_rdy = (m_q.size() < DEPTH);
      m_err = cmd_valid && m_rdy && !abort && (cmd_key >= 42);
      if (abort) begin
        m_q.delete(); m_key = -1; m_press = 0; m_gap = GAP;
      end else begin
        if (m_press > 0) begin
          m_press--;
          if (m_press == 0) begin m_key = -1; m_gap = GAP; end
        end else if (m_gap > 1) begin
          m_gap--;
        end else begin
          m_gap = 0;
          if (m_q.size() > 0) begin m_key = m_q.pop_front(); m_press = PRESS; end
        end
        if (cmd_valid && m_rdy && cmd_key < 42) m_q.push_back(int'(cmd_key));
      end
    end
  end

  always @(negedge clk) begin
    logic [41:0] e_state;
    if (chk_en) begin
      e_state = (m_key >= 0) ? (42'(1) << m_key) : 42'd0;
      chk("state", 64'(state), 64'(e_state));
      chk("fifo_count", 64'(fifo_count), 64'(m_q.size()));
      chk("cmd_ready", 64'(cmd_ready), 64'(m_q.size() < DEPTH));
      chk("busy", 64'(busy), 64'((m_key >= 0) || (m_gap > 0) || (m_q.size() > 0)));
      chk("err_pulse", 64'(err_pulse), 64'(m_err));
    end
  end

  task automatic push(input logic [5:0] k);
    int g = 0;
    logic took;
    cmd_valid = 1; cmd_key = k;
    do begin took = cmd_ready; @(negedge clk); g++; end while (!took && g < 64);
    cmd_valid = 0;
    if (!took) chk("push_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int g = 0;
    while (busy && g < 200) begin @(negedge clk); g++; end
    chk("idle_timeout", 64'(busy), 0);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    chk("rst_state", 64'(state), 0);
    chk("rst_ready", 64'(cmd_ready), 1);
    chk("rst_busy", 64'(busy), 0);
    chk_en = 1;

    // 1: async reset during a press
    push(6'd5);
    @(negedge clk);
    chk("t1_pressed", 64'(state), 64'(42'(1) << 5));
    #2 rst_n = 0;
    #1;
    chk("t1_state", 64'(state), 0);
    chk("t1_ready", 64'(cmd_ready), 1);
    chk("t1_count", 64'(fifo_count), 0);
    chk("t1_busy", 64'(busy), 0);
    @(negedge clk); #2 rst_n = 1;
    @(negedge clk);

    // 2: single key 10, two-cycle latency, 4 press + 3 gap
    push(6'd10);
    chk("t2_lat", 64'(state), 0);
    @(negedge clk);
    chk("t2_bit13", 64'(state[1][3]), 1);
    for (int i = 0; i < PRESS; i++) begin
      chk("t2_press", 64'(state), 64'(42'(1) << 10));
      @(negedge clk);
    end
    for (int i = 0; i < GAP; i++) begin
      chk("t2_gap", 64'(state), 0);
      chk("t2_gapbusy", 64'(busy), 1);
      @(negedge clk);
    end
    chk("t2_done", 64'(busy), 0);

    // 3: 0, 41, 41 back to back: 22 busy cycles from the first handshake
    cmd_valid = 1; cmd_key = 6'd0;
    @(negedge clk);
    n = 0;
    if (busy) n++;
    cmd_key = 6'd41; @(negedge clk);
    if (busy) n++;
    cmd_key = 6'd41; @(negedge clk);
    cmd_valid = 0;
    while (busy && n < 100) begin n++; @(negedge clk); end
    chk("t3_busy_len", 64'(n), 22);

    // 4: fill during a press, fifth command stalls until the next pop
    push(6'd7);
    @(negedge clk);
    for (int i = 1; i <= 4; i++) push(6'(i));
    chk("t4_ready", 64'(cmd_ready), 0);
    chk("t4_count", 64'(fifo_count), 4);
    push(6'd20);
    chk("t4_after", 64'(fifo_count), 4);
    wait_idle();

    // 5: illegal code
    push(6'd50);
    chk("t5_err", 64'(err_pulse), 1);
    chk("t5_count", 64'(fifo_count), 0);
    chk("t5_state", 64'(state), 0);
    @(negedge clk);
    chk("t5_err_off", 64'(err_pulse), 0);

    // 6: abort during first press; a command in the abort cycle is dropped
    push(6'd1); push(6'd2); push(6'd3);
    chk("t6_pressed", 64'(state), 64'(42'(1) << 1));
    abort = 1; cmd_valid = 1; cmd_key = 6'd50;
    @(negedge clk);
    abort = 0; cmd_valid = 0;
    chk("t6_state", 64'(state), 0);
    chk("t6_count", 64'(fifo_count), 0);
    chk("t6_noerr", 64'(err_pulse), 0);
    chk("t6_busy0", 64'(busy), 1);
    @(negedge clk);
    @(negedge clk);
    chk("t6_busy2", 64'(busy), 1);
    @(negedge clk);
    chk("t6_idle", 64'(busy), 0);

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      cmd_valid = ($urandom % 3) == 0;
      cmd_key = (($urandom % 8) == 0) ? 6'($urandom_range(63, 42)) : 6'($urandom_range(41, 0));
      abort = ($urandom % 97) == 0;
      @(negedge clk);
    end
    cmd_valid = 0; abort = 0;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
